// File: rtl/gearbox_sched.sv
// Streaming IN_W -> OUT_W width converter with LSB-first packing, phase tracking
// and a flush path that drains and zero-pads the residue.
module gearbox_sched #(
  parameter int IN_W   = 21,
  parameter int OUT_W  = 10,
  parameter int PERIOD = 10,
  parameter int CNT_W  = 6,
  parameter int PH_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  input  logic             flush,
  output logic             flush_done,
  output logic [PH_W-1:0]  phase,
  output logic             frame_start,
  output logic [CNT_W-1:0] occupancy
);

  localparam int ACC_W = IN_W + 2 * OUT_W - 1;

  localparam logic RUN   = 1'b0;
  localparam logic DRAIN = 1'b1;

  logic             state;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;

  logic             push;
  logic             pop;
  logic             phase_wrap;
  logic [ACC_W-1:0] acc_pop;
  logic [CNT_W-1:0] cnt_pop;
  logic [ACC_W-1:0] acc_next;
  logic [CNT_W-1:0] cnt_next;

  // Handshake outputs depend on registered state only.
  assign out_valid = (cnt >= CNT_W'(OUT_W)) || (state == DRAIN && cnt != '0);
  assign out_data  = acc[OUT_W-1:0];
  assign out_last  = out_valid && state == DRAIN && cnt <= CNT_W'(OUT_W);
  assign in_ready  = state == RUN && cnt < CNT_W'(2 * OUT_W);
  assign occupancy = cnt;

  assign pop        = out_valid && out_ready;
  assign push       = in_valid && in_ready;
  assign phase_wrap = phase == PH_W'(PERIOD - 1);

  // A beat pushed alongside a pop lands at the post-pop count.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no latch can be inferred.
    acc_pop  = acc;
    cnt_pop  = cnt;
    if (pop) begin
      acc_pop = acc >> OUT_W;
      cnt_pop = (cnt > CNT_W'(OUT_W)) ? cnt - CNT_W'(OUT_W) : '0;
    end
    acc_next = acc_pop;
    cnt_next = cnt_pop;
    if (push) begin
      acc_next = acc_pop | (ACC_W'(in_data) << cnt_pop);
      cnt_next = cnt_pop + CNT_W'(IN_W);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: acc is cleared too; bits above cnt must read as zero for the padded final word.
      acc         <= '0;
      cnt         <= '0;
      state       <= RUN;
      phase       <= '0;
      frame_start <= 1'b0;
      flush_done  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register sees pre-edge values.
      acc         <= acc_next;
      cnt         <= cnt_next;
      frame_start <= push && phase_wrap;
      flush_done  <= 1'b0;
      if (push) phase <= phase_wrap ? '0 : phase + PH_W'(1);
      case (state)
        RUN: if (flush) state <= DRAIN;
        DRAIN: begin
          if (cnt_next == '0) begin
            state      <= RUN;
            flush_done <= 1'b1;
            phase      <= '0;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule
